// File: rtl/prio_encoder_drain.sv
// Latches an N-bit request vector and drains the index of every set bit, one per handshake, in priority order.
// Optional input masking at load time is enabled by defining PRIO_ENCODER_DRAIN_MASK_EN.
module prio_encoder_drain #(
    parameter int unsigned N         = 8,
    parameter int unsigned MSB_FIRST = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [N-1:0]         in_vec,
`ifdef PRIO_ENCODER_DRAIN_MASK_EN
    input  logic [N-1:0]         mask_in,
`endif
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [$clog2(N)-1:0] out_idx,
    output logic                 out_last,
    output logic                 busy,
    output logic                 empty_err
);

    localparam int unsigned W = $clog2(N);
    localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

    typedef enum logic {
        IDLE  = 1'b0,
        DRAIN = 1'b1
    } state_e;

    state_e         state_q, state_d;
    logic [N-1:0]   pending_q, pending_d;
    logic           empty_err_q, empty_err_d;
    logic [N-1:0]   load_vec;
    logic [W-1:0]   sel_idx;
    logic           single_bit;

`ifdef PRIO_ENCODER_DRAIN_MASK_EN
    assign load_vec = in_vec & ~mask_in;
`else
    assign load_vec = in_vec;
`endif

    // Priority encode: the last set bit visited by the loop wins.
    always_comb begin
        sel_idx = '0;
        if (MSB_FIRST != 0) begin
            for (int i = 0; i < N; i++) begin
                if (pending_q[i]) sel_idx = W'(i);
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                if (pending_q[N-1-i]) sel_idx = W'(N-1-i);
            end
        end
    end

    assign single_bit = (pending_q != '0) && ((pending_q & (pending_q - ONE)) == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            pending_q   <= '0;
            empty_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pending_q   <= pending_d;
            empty_err_q <= empty_err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        pending_d   = pending_q;
        empty_err_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    if (load_vec != '0) begin
                        pending_d = load_vec;
                        state_d   = DRAIN;
                    end else begin
                        empty_err_d = 1'b1;
                    end
                end
            end
            DRAIN: begin
                if (out_ready) begin
                    pending_d = pending_q & ~(ONE << sel_idx);
                    if (single_bit) state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign in_ready  = (state_q == IDLE) && !rst;
    assign out_valid = (state_q == DRAIN);
    assign out_idx   = out_valid ? sel_idx : '0;
    assign out_last  = out_valid && single_bit;
    assign busy      = (pending_q != '0);
    assign empty_err = empty_err_q;

endmodule

// File: tb/tb_prio_encoder_drain.sv
// Directed bench for prio_encoder_drain: MSB-first and LSB-first instances, plus masking when enabled.
module tb_prio_encoder_drain;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid, in_ready, out_valid, out_ready, out_last, busy, empty_err;
    logic [7:0] in_vec;
    logic [2:0] out_idx;
`ifdef PRIO_ENCODER_DRAIN_MASK_EN
    logic [7:0] mask_in;
`endif

    logic       l_in_valid, l_in_ready, l_out_valid, l_out_ready, l_out_last, l_busy, l_empty_err;
    logic [7:0] l_in_vec;
    logic [2:0] l_out_idx;
`ifdef PRIO_ENCODER_DRAIN_MASK_EN
    logic [7:0] l_mask_in;
`endif

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    prio_encoder_drain #(.N(8), .MSB_FIRST(1)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_vec(in_vec),
`ifdef PRIO_ENCODER_DRAIN_MASK_EN
        .mask_in(mask_in),
`endif
        .out_valid(out_valid), .out_ready(out_ready), .out_idx(out_idx),
        .out_last(out_last), .busy(busy), .empty_err(empty_err)
    );

    prio_encoder_drain #(.N(8), .MSB_FIRST(0)) dut_lsb (
        .clk(clk), .rst(rst),
        .in_valid(l_in_valid), .in_ready(l_in_ready), .in_vec(l_in_vec),
`ifdef PRIO_ENCODER_DRAIN_MASK_EN
        .mask_in(l_mask_in),
`endif
        .out_valid(l_out_valid), .out_ready(l_out_ready), .out_idx(l_out_idx),
        .out_last(l_out_last), .busy(l_busy), .empty_err(l_empty_err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer one vector for exactly one cycle; outputs after return reflect the load edge.
    task automatic load(input logic [7:0] v);
        in_valid = 1'b1;
        in_vec   = v;
        tick();
        in_valid = 1'b0;
        in_vec   = 8'h00;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; in_vec = 8'h00; out_ready = 1'b1;
        l_in_valid = 1'b0; l_in_vec = 8'h00; l_out_ready = 1'b1;
`ifdef PRIO_ENCODER_DRAIN_MASK_EN
        mask_in = 8'h00; l_mask_in = 8'h00;
`endif
        repeat (3) tick();
        total++;
        if ({out_valid, out_idx, out_last, busy, empty_err} !== 7'b0)
            $display("FAIL reset_outputs: got v=%b idx=%0d last=%b busy=%b err=%b, want all 0",
                     out_valid, out_idx, out_last, busy, empty_err);
        else passed++;
        rst = 1'b0;
        #1;
        total++;
        if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", in_ready);
        else passed++;
    endtask

    task automatic test_drain_a5();
        logic [2:0] exp_idx [4] = '{3'd7, 3'd5, 3'd2, 3'd0};
        load(8'hA5);
        for (int k = 0; k < 4; k++) begin
            total++;
            if (out_valid !== 1'b1 || out_idx !== exp_idx[k] || out_last !== (k == 3) || in_ready !== 1'b0)
                $display("FAIL drain_a5[%0d]: got v=%b idx=%0d last=%b rdy=%b, want v=1 idx=%0d last=%b rdy=0",
                         k, out_valid, out_idx, out_last, in_ready, exp_idx[k], (k == 3));
            else passed++;
            tick();
        end
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0 || out_idx !== 3'd0)
            $display("FAIL drain_a5_idle: got v=%b rdy=%b busy=%b idx=%0d, want 0 1 0 0",
                     out_valid, in_ready, busy, out_idx);
        else passed++;
    endtask

    task automatic test_single_bit();
        load(8'h80);
        total++;
        if (out_valid !== 1'b1 || out_idx !== 3'd7 || out_last !== 1'b1 || busy !== 1'b1)
            $display("FAIL single_bit: got v=%b idx=%0d last=%b busy=%b, want 1 7 1 1",
                     out_valid, out_idx, out_last, busy);
        else passed++;
        tick();
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1)
            $display("FAIL single_bit_done: got v=%b rdy=%b, want 0 1", out_valid, in_ready);
        else passed++;
    endtask

    task automatic test_empty_vec();
        load(8'h00);
        total++;
        if (empty_err !== 1'b1 || out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0)
            $display("FAIL empty_pulse: got err=%b v=%b rdy=%b busy=%b, want 1 0 1 0",
                     empty_err, out_valid, in_ready, busy);
        else passed++;
        tick();
        total++;
        if (empty_err !== 1'b0 || out_valid !== 1'b0)
            $display("FAIL empty_pulse_end: got err=%b v=%b, want 0 0", empty_err, out_valid);
        else passed++;
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        load(8'h12);
        for (int k = 0; k < 5; k++) begin
            total++;
            if (out_valid !== 1'b1 || out_idx !== 3'd4 || out_last !== 1'b0)
                $display("FAIL stall[%0d]: got v=%b idx=%0d last=%b, want 1 4 0", k, out_valid, out_idx, out_last);
            else passed++;
            if (k < 4) tick();
        end
        out_ready = 1'b1;
        tick();
        total++;
        if (out_valid !== 1'b1 || out_idx !== 3'd1 || out_last !== 1'b1)
            $display("FAIL stall_resume: got v=%b idx=%0d last=%b, want 1 1 1", out_valid, out_idx, out_last);
        else passed++;
        tick();
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1)
            $display("FAIL stall_done: got v=%b rdy=%b, want 0 1", out_valid, in_ready);
        else passed++;
    endtask

    task automatic test_reset_mid_drain();
        load(8'hFF);
        repeat (3) tick();
        total++;
        if (out_idx !== 3'd4) $display("FAIL pre_reset_idx: got %0d want 4", out_idx);
        else passed++;
        rst = 1'b1;
        #1;
        total++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || out_idx !== 3'd0 || out_last !== 1'b0)
            $display("FAIL async_reset: got v=%b busy=%b idx=%0d last=%b, want 0 0 0 0",
                     out_valid, busy, out_idx, out_last);
        else passed++;
        tick();
        rst = 1'b0;
        #1;
        load(8'h01);
        total++;
        if (out_valid !== 1'b1 || out_idx !== 3'd0 || out_last !== 1'b1)
            $display("FAIL post_reset_load: got v=%b idx=%0d last=%b, want 1 0 1", out_valid, out_idx, out_last);
        else passed++;
        tick();
    endtask

    task automatic test_back_to_back();
        // Next vector is offered throughout the drain; it must only be taken once in_ready returns.
        in_valid = 1'b1;
        in_vec   = 8'h03;
        tick();
        in_vec   = 8'h40;
        total++;
        if (out_idx !== 3'd1 || out_last !== 1'b0)
            $display("FAIL b2b_first: got idx=%0d last=%b, want 1 0", out_idx, out_last);
        else passed++;
        tick();
        total++;
        if (out_idx !== 3'd0 || out_last !== 1'b1 || in_ready !== 1'b0)
            $display("FAIL b2b_last: got idx=%0d last=%b rdy=%b, want 0 1 0", out_idx, out_last, in_ready);
        else passed++;
        tick();
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1)
            $display("FAIL b2b_gap: got v=%b rdy=%b, want 0 1", out_valid, in_ready);
        else passed++;
        tick();
        in_valid = 1'b0;
        in_vec   = 8'h00;
        total++;
        if (out_valid !== 1'b1 || out_idx !== 3'd6 || out_last !== 1'b1)
            $display("FAIL b2b_second: got v=%b idx=%0d last=%b, want 1 6 1", out_valid, out_idx, out_last);
        else passed++;
        tick();
    endtask

    task automatic test_lsb_first();
        logic [2:0] exp_idx [4] = '{3'd0, 3'd2, 3'd5, 3'd7};
        l_in_valid = 1'b1;
        l_in_vec   = 8'hA5;
        tick();
        l_in_valid = 1'b0;
        l_in_vec   = 8'h00;
        for (int k = 0; k < 4; k++) begin
            total++;
            if (l_out_valid !== 1'b1 || l_out_idx !== exp_idx[k] || l_out_last !== (k == 3))
                $display("FAIL lsb_first[%0d]: got v=%b idx=%0d last=%b, want 1 %0d %b",
                         k, l_out_valid, l_out_idx, l_out_last, exp_idx[k], (k == 3));
            else passed++;
            tick();
        end
        total++;
        if (l_out_valid !== 1'b0 || l_in_ready !== 1'b1)
            $display("FAIL lsb_done: got v=%b rdy=%b, want 0 1", l_out_valid, l_in_ready);
        else passed++;
    endtask

`ifdef PRIO_ENCODER_DRAIN_MASK_EN
    task automatic test_mask();
        mask_in = 8'h30;
        load(8'hF0);
        total++;
        if (out_valid !== 1'b1 || out_idx !== 3'd7 || out_last !== 1'b0)
            $display("FAIL mask_first: got v=%b idx=%0d last=%b, want 1 7 0", out_valid, out_idx, out_last);
        else passed++;
        tick();
        total++;
        if (out_idx !== 3'd6 || out_last !== 1'b1)
            $display("FAIL mask_second: got idx=%0d last=%b, want 6 1", out_idx, out_last);
        else passed++;
        tick();
        load(8'h30);
        total++;
        if (empty_err !== 1'b1 || out_valid !== 1'b0 || in_ready !== 1'b1)
            $display("FAIL mask_empty: got err=%b v=%b rdy=%b, want 1 0 1", empty_err, out_valid, in_ready);
        else passed++;
        mask_in = 8'h00;
        tick();
    endtask
`endif

    initial begin
        test_reset();
        test_drain_a5();
        test_single_bit();
        test_empty_vec();
        test_backpressure();
        test_reset_mid_drain();
        test_back_to_back();
        test_lsb_first();
`ifdef PRIO_ENCODER_DRAIN_MASK_EN
        test_mask();
`endif
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
